// File: rtl/npc_bp_pkg.sv
// npc_bp_pkg: shared types and helpers for next-PC generation and the BTB.
// Holds the 2-bit counter encoding, BTB geometry helpers and counter update rule.
package npc_bp_pkg;

    // 2-bit saturating branch counter; bit 1 is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_cnt_e;

    // Default geometry of the core's BTB.
    localparam int unsigned XLEN_DEF    = 32;
    localparam int unsigned BTB_ENTRIES = 16;
    localparam int unsigned BTB_IDX_W   = $clog2(BTB_ENTRIES);
    localparam int unsigned BTB_TAG_W   = XLEN_DEF - BTB_IDX_W - 2;

    // Counter value after reset and on a fresh allocation.
    localparam bp_cnt_e CNT_RESET = WNT;
    localparam bp_cnt_e CNT_ALLOC = WT;

    function automatic int unsigned btb_idx_w(input int unsigned entries);
        return $clog2(entries);
    endfunction

    function automatic int unsigned btb_tag_w(input int unsigned xlen,
                                              input int unsigned entries);
        return xlen - $clog2(entries) - 2;
    endfunction

    // Saturating step: 11 stays 11 when taken, 00 stays 00 when not taken.
    function automatic bp_cnt_e cnt_step(input bp_cnt_e c, input logic taken);
        bp_cnt_e r;
        r = c;
        if (taken && c != ST) begin
            r = bp_cnt_e'(c + 2'b01);
        end else if (!taken && c != SNT) begin
            r = bp_cnt_e'(c - 2'b01);
        end
        return r;
    endfunction

endpackage

// File: rtl/npc_bp_if.sv
// npc_bp_if: fetch-side and EX-side signal bundle of the next-PC unit.
// slave = npc_bp itself, master = the pipeline (or a testbench) driving it.
interface npc_bp_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             stall_i;
    logic [XLEN-1:0]  pc_o;
    logic             pred_taken_o;
    logic [XLEN-1:0]  pred_target_o;
    logic             ex_valid_i;
    logic [XLEN-1:0]  ex_pc_i;
    logic             ex_is_branch_i;
    logic             ex_is_jal_i;
    logic             ex_is_jalr_i;
    logic             ex_taken_i;
    logic [XLEN-1:0]  ex_target_i;
    logic             ex_pred_taken_i;
    logic [XLEN-1:0]  ex_pred_target_i;
    logic             flush_o;
    logic [CNT_W-1:0] mispredict_cnt_o;

    modport slave (
        input  stall_i, ex_valid_i, ex_pc_i, ex_is_branch_i, ex_is_jal_i,
               ex_is_jalr_i, ex_taken_i, ex_target_i, ex_pred_taken_i,
               ex_pred_target_i,
        output pc_o, pred_taken_o, pred_target_o, flush_o, mispredict_cnt_o
    );

    modport master (
        output stall_i, ex_valid_i, ex_pc_i, ex_is_branch_i, ex_is_jal_i,
               ex_is_jalr_i, ex_taken_i, ex_target_i, ex_pred_taken_i,
               ex_pred_target_i,
        input  pc_o, pred_taken_o, pred_target_o, flush_o, mispredict_cnt_o
    );
endinterface

// File: rtl/npc_bp_btb.sv
// bp_btb: direct-mapped branch target buffer with 2-bit counters.
// Ports: rd_pc -> rd_taken/rd_target (combinational lookup);
// upd_* resolved branch/JAL from EX, written on the clock edge.
module bp_btb
    import npc_bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-3:0] rd_pc,
    output logic            rd_taken,
    output logic [XLEN-1:0] rd_target,
    input  logic            upd_en,
    input  logic [XLEN-3:0] upd_pc,
    input  logic            upd_is_branch,
    input  logic            upd_is_jal,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target
);
    localparam int IDX   = int'(btb_idx_w(ENTRIES));
    localparam int TAG_W = int'(btb_tag_w(XLEN, ENTRIES));

    logic             valid_q  [ENTRIES];
    bp_cnt_e          cnt_q    [ENTRIES];
    logic             jal_q    [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];

    logic [IDX-1:0]   rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_hit;
    logic [IDX-1:0]   wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             wr_hit;
    logic             wr_cnt;
    logic             wr_tgt;
    logic             wr_alloc;

    // rd_pc/upd_pc arrive without the two byte-offset bits.
    assign rd_idx = rd_pc[IDX-1:0];
    assign rd_tag = rd_pc[XLEN-3:IDX];
    assign wr_idx = upd_pc[IDX-1:0];
    assign wr_tag = upd_pc[XLEN-3:IDX];

    // Reads come straight from the arrays, so a same-cycle update to the
    // same index is only visible from the next cycle on.
    assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_taken  = rd_hit && (jal_q[rd_idx] || cnt_q[rd_idx][1]);
    assign rd_target = target_q[rd_idx];

    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    always_comb begin
        wr_cnt   = 1'b0;
        wr_tgt   = 1'b0;
        wr_alloc = 1'b0;
        if (upd_en) begin
            if (wr_hit) begin
                wr_cnt = upd_is_branch;
                wr_tgt = upd_is_jal || (upd_is_branch && upd_taken);
            end else if (upd_taken) begin
                wr_alloc = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= CNT_RESET;
            end
        end else if (wr_alloc) begin
            valid_q[wr_idx] <= 1'b1;
            cnt_q[wr_idx]   <= CNT_ALLOC;
        end else if (wr_cnt) begin
            cnt_q[wr_idx] <= cnt_step(cnt_q[wr_idx], upd_taken);
        end
    end

    // Payload is not reset; valid gates it. Writes are suppressed while
    // rst is high so an aborted update leaves nothing behind.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (wr_alloc) begin
                tag_q[wr_idx]    <= wr_tag;
                jal_q[wr_idx]    <= upd_is_jal;
                target_q[wr_idx] <= upd_target;
            end else if (wr_tgt) begin
                target_q[wr_idx] <= upd_target;
            end
        end
    end

endmodule

// File: rtl/npc_bp.sv
// npc_bp: fetch PC register, BTB prediction, EX mispredict redirect.
// Ports: clk, rst (async high); bus (npc_bp_if.slave) carries stall,
// prediction outputs, EX resolution inputs, flush and mispredict count.
module npc_bp
    import npc_bp_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              ENTRIES  = 16,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input logic      clk,
    input logic      rst,
    npc_bp_if.slave  bus
);
    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_d;
    logic [XLEN-1:0]  seq_pc;
    logic [XLEN-1:0]  redirect;
    logic             btb_taken;
    logic [XLEN-1:0]  btb_target;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
    logic             ctl;
    logic             mis;
    logic             upd_en;
    logic [CNT_W-1:0] cnt_q;

    assign seq_pc = pc_q + XLEN'(4);

    bp_btb #(
        .XLEN    (XLEN),
        .ENTRIES (ENTRIES)
    ) u_btb (
        .clk           (clk),
        .rst           (rst),
        .rd_pc         (pc_q[XLEN-1:2]),
        .rd_taken      (btb_taken),
        .rd_target     (btb_target),
        .upd_en        (upd_en),
        .upd_pc        (bus.ex_pc_i[XLEN-1:2]),
        .upd_is_branch (bus.ex_is_branch_i),
        .upd_is_jal    (bus.ex_is_jal_i),
        .upd_taken     (bus.ex_taken_i),
        .upd_target    (bus.ex_target_i)
    );

    assign pred_taken  = btb_taken && !rst;
    assign pred_target = pred_taken ? btb_target : seq_pc;

    assign ctl = bus.ex_valid_i &&
                 (bus.ex_is_branch_i || bus.ex_is_jal_i || bus.ex_is_jalr_i);

    // A wrong target only matters when the instruction was actually taken.
    assign mis = ctl && !rst &&
                 ((bus.ex_taken_i != bus.ex_pred_taken_i) ||
                  (bus.ex_taken_i &&
                   (bus.ex_target_i != bus.ex_pred_target_i)));

    // JALR targets are data dependent, so they never enter the BTB.
    assign upd_en = ctl && (bus.ex_is_branch_i || bus.ex_is_jal_i);

    assign redirect = bus.ex_taken_i ? bus.ex_target_i
                                     : bus.ex_pc_i + XLEN'(4);

    always_comb begin
        pc_d = pred_target;
        if (mis) begin
            pc_d = redirect;
        end else if (bus.stall_i) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (mis && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.pc_o             = pc_q;
    assign bus.pred_taken_o     = pred_taken;
    assign bus.pred_target_o    = pred_target;
    assign bus.flush_o          = mis;
    assign bus.mispredict_cnt_o = cnt_q;

endmodule

// File: doc/npc_bp.md
Name: npc_bp

Overview:
- Parametrised next-PC generation unit for the pipelined RV32 core.
- Owns the fetch PC register and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so taken branches and JALs are predicted at fetch.
- Accepts resolved control-flow outcomes from EX, detects mispredictions, and issues a redirect plus flush.
- Replaces the purely combinational next-PC selection, which always redirected from EX.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 16, BTB entry count; power of two, at least 2.
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- CNT_W, 16, width of the mispredict counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_i  in  1  hold the fetch PC (IF/ID stall).
- pc_o  out  XLEN  current fetch PC.
- pred_taken_o  out  1  prediction for pc_o; travels down the pipe with the instruction.
- pred_target_o  out  XLEN  predicted target for pc_o; equals pc_o+4 when not predicted taken.
- ex_valid_i  in  1  EX holds a valid resolved instruction.
- ex_pc_i  in  XLEN  PC of the EX instruction.
- ex_is_branch_i  in  1  conditional branch.
- ex_is_jal_i  in  1  JAL.
- ex_is_jalr_i  in  1  JALR.
- ex_taken_i  in  1  actual outcome; 1 for JAL and JALR.
- ex_target_i  in  XLEN  actual target (PC+IMM, or ALU result for JALR).
- ex_pred_taken_i  in  1  prediction carried with the EX instruction.
- ex_pred_target_i  in  XLEN  predicted target carried with the EX instruction.
- flush_o  out  1  mispredict; kill IF/ID and ID/EX.
- mispredict_cnt_o  out  CNT_W  saturating count of mispredictions.

Behaviour:
- Reset (async, rst=1):
  - pc_o=RESET_PC.
  - All BTB valid bits cleared; counters set to 01 (weakly not-taken).
  - mispredict_cnt_o=0.
  - pred_taken_o=0, flush_o=0 while in reset.
- Reset asserted mid-operation aborts any pending update; no partial BTB write survives.
- Lookup (combinational on pc_o):
  - Index = pc_o[IDX+1:2], IDX=log2(ENTRIES); tag = pc_o[XLEN-1:IDX+2].
  - Hit = valid && tag match.
  - pred_taken_o = hit && (is_jal_flag || cnt[1]).
  - pred_target_o = pred_taken_o ? entry target : pc_o+4.
- Mispredict (combinational):
  - ctl = ex_valid_i && (branch | jal | jalr).
  - mis = ctl && ((ex_taken_i != ex_pred_taken_i) || (ex_taken_i && ex_target_i != ex_pred_target_i)).
  - flush_o = mis, in the same cycle.
  - Redirect target = ex_taken_i ? ex_target_i : ex_pc_i+4.
- Next PC, applied at the clock edge, in priority order:
  1. mis → redirect target.
  2. stall_i → hold.
  3. Otherwise → pred_target_o.
- All PC arithmetic is modulo 2^XLEN; wrap-around past all-ones is legal.
- BTB update (registered, on the clock edge when ctl && (branch | jal)):
  - Hit on ex_pc_i, branch: counter saturating +1 if taken, -1 if not (11 stays 11, 00 stays 00). Target written when taken.
  - Hit on ex_pc_i, JAL: target rewritten.
  - Miss and taken: allocate the entry, overwriting any alias. Set tag, target, valid=1, is_jal_flag=ex_is_jal_i, counter=10.
  - Miss and not taken: no write.
  - JALR never updates the BTB; JALR is predicted not-taken and is always redirected from EX.
- Update and lookup of the same index in one cycle: lookup sees the pre-update contents (write-first is forbidden).
- Stall does not block BTB updates or the redirect.
- mispredict_cnt_o increments by 1 on each clock with mis=1 and saturates at all-ones.

Decomposition:
- Shared package (ctrl_encode_def side):
  - Counter encodings: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - BTB index/tag width localparams derived from ENTRIES and XLEN.
  - Reset counter value (WNT).
- Sub-module bp_btb: storage array, tag compare, read port, and the update/allocate/saturation logic.
- npc_bp: PC register, mispredict detection, next-PC mux, performance counter.

Test Plan:
1. Reset and sequential fetch: assert rst asynchronously between edges → pc_o=0, flush_o=0, count 0 immediately. After release with no control flow → pc_o = 0, 4, 8, 0xC on successive edges.
2. Cold taken branch: branch at 0x10, taken, target 0x40, pred 0 → flush_o=1 that cycle, pc_o=0x40 next edge, count=1. On a later fetch of 0x10 → pred_taken_o=1, pred_target_o=0x40.
3. Hysteresis: from counter 10, one not-taken resolve of 0x10 (pred 1) → flush, redirect to 0x14, counter 01. Next fetch of 0x10 → pred_taken_o=0. Two taken resolves from 01 → 10, then 11.
4. Stall priority: stall_i=1 for 3 cycles → pc_o holds. stall_i=1 and mis=1 in the same cycle → pc_o takes the redirect target.
5. Aliasing, ENTRIES=16: 0x10 allocated, then 0x50 (same index 4, different tag) resolved taken to 0x80 → entry overwritten. Fetch 0x10 misses (pred 0); fetch 0x50 predicts 0x80.
6. JALR and counter saturation: JALR at 0x20 to 0x200 → flush every time, no BTB entry created. Force CNT_W=4 and 17 mispredicts → mispredict_cnt_o=4'hF.
